error_recovery_ctrl: RTL and testbench

ERROR_RECOVERY_CTRL -- requirements
Module: error_recovery_ctrl

---
 rtl/err_rec_pkg.sv | 19 +
 rtl/err_rate_monitor.sv | 81 ++++++++
 rtl/error_recovery_ctrl.sv | 104 ++++++++++
 tb/tb_error_recovery_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/err_rec_pkg.sv
// Shared FSM encoding and default parameter constants for the error recovery controller.
package err_rec_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 3;
  localparam int unsigned DEF_REPLAY_CYCLES = 2;
  localparam int unsigned DEF_WINDOW        = 64;
  localparam int unsigned DEF_ERR_THRESH    = 4;
  localparam int unsigned DEF_CNT_W         = 8;

  // Replay down-counter width; REPLAY_CYCLES is limited to 1..15.
  localparam int unsigned REPLAY_CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESTORE = 2'd1,
    ST_REPLAY  = 2'd2
  } rec_state_e;

endpackage

// File: rtl/err_rate_monitor.sv
// Windowed error-rate monitor: requests a slower clock when errors cluster,
// hints a speed-up when a full window passes without errors.
module err_rate_monitor
  import err_rec_pkg::*;
#(
  parameter int unsigned WINDOW     = DEF_WINDOW,
  parameter int unsigned ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic clk,
  input  logic rst,
  input  logic err_acc_i,
  input  logic slow_ack_i,
  output logic slow_req_o,
  output logic speed_up_o
);

  localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0] win_err_q, win_err_d;
  logic             slow_req_q, slow_req_d;
  logic             speed_up_q, speed_up_d;
  logic             wrap_c;
  logic             err_inc_c;

  assign wrap_c    = (win_cnt_q == WIN_W'(WINDOW - 1));
  assign err_inc_c = err_acc_i && (win_err_q < ERR_W'(ERR_THRESH));

  // Next-state: window advance/wrap, saturating error tally, slow request handshake.
  always_comb begin
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    slow_req_d = slow_req_q;
    speed_up_d = 1'b0;
    if (slow_req_q) begin
      // Window is frozen while the clock manager is being asked to slow down.
      if (slow_ack_i) begin
        slow_req_d = 1'b0;
        win_cnt_d  = '0;
        win_err_d  = '0;
      end else if (err_inc_c) begin
        win_err_d = win_err_q + ERR_W'(1);
      end
    end else begin
      if (win_err_q >= ERR_W'(ERR_THRESH)) begin
        slow_req_d = 1'b1;
      end
      if (wrap_c) begin
        win_cnt_d  = '0;
        speed_up_d = (win_err_q == '0);
        // An error accepted on the wrap edge belongs to the new window.
        win_err_d  = err_acc_i ? ERR_W'(1) : '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        if (err_inc_c) begin
          win_err_d = win_err_q + ERR_W'(1);
        end
      end
    end
  end

  // Monitor state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      slow_req_q <= 1'b0;
      speed_up_q <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      slow_req_q <= slow_req_d;
      speed_up_q <= speed_up_d;
    end
  end

  assign slow_req_o = slow_req_q;
  assign speed_up_o = speed_up_q;

endmodule

// File: rtl/error_recovery_ctrl.sv
// Timing-error recovery controller: restores shadow data, stalls for replay,
// counts accepted errors and drives the clock-rate handshake.
module error_recovery_ctrl
  import err_rec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned REPLAY_CYCLES = DEF_REPLAY_CYCLES,
  parameter int unsigned WINDOW        = DEF_WINDOW,
  parameter int unsigned ERR_THRESH    = DEF_ERR_THRESH,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  err_in,
  input  logic [DATA_WIDTH-1:0] shadow_d,
  input  logic                  en,
  input  logic                  slow_ack,
  output logic                  stall,
  output logic                  restore,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  slow_req,
  output logic                  speed_up,
  output logic [CNT_W-1:0]      err_cnt,
  output logic                  busy
);

  rec_state_e              state_q;
  logic [REPLAY_CNT_W-1:0] rep_cnt_q;
  logic                    stall_q;
  logic                    restore_q;
  logic                    busy_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]        err_cnt_q;
  logic                    accept_c;

  // Errors are only accepted from IDLE; anything arriving mid-recovery is masked.
  assign accept_c = (state_q == ST_IDLE) && err_in && en;

  // Recovery FSM with registered outputs and saturating total error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      stall_q   <= 1'b0;
      restore_q <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      err_cnt_q <= '0;
    end else begin
      restore_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          data_q <= shadow_d;
          if (accept_c) begin
            state_q   <= ST_RESTORE;
            restore_q <= 1'b1;
            stall_q   <= 1'b1;
            busy_q    <= 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RESTORE: begin
          state_q   <= ST_REPLAY;
          rep_cnt_q <= REPLAY_CNT_W'(REPLAY_CYCLES - 1);
        end
        ST_REPLAY: begin
          if (rep_cnt_q == '0) begin
            state_q <= ST_IDLE;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
          end else begin
            rep_cnt_q <= rep_cnt_q - REPLAY_CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          stall_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  err_rate_monitor #(
    .WINDOW     (WINDOW),
    .ERR_THRESH (ERR_THRESH)
  ) u_rate_mon (
    .clk        (clk),
    .rst        (rst),
    .err_acc_i  (accept_c),
    .slow_ack_i (slow_ack),
    .slow_req_o (slow_req),
    .speed_up_o (speed_up)
  );

  assign stall    = stall_q;
  assign restore  = restore_q;
  assign busy     = busy_q;
  assign data_out = data_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_error_recovery_ctrl.sv
// Directed self-checking bench for error_recovery_ctrl (default instance plus a CNT_W=2 instance).
module tb_error_recovery_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       err_in, en, slow_ack;
  logic [2:0] shadow_d;
  logic       stall, restore, slow_req, speed_up, busy;
  logic [2:0] data_out;
  logic [7:0] err_cnt;

  logic       err2, en2;
  logic       stall2, restore2, slow_req2, speed_up2, busy2;
  logic [2:0] data_out2;
  logic [1:0] err_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  error_recovery_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .err_in   (err_in),
    .shadow_d (shadow_d),
    .en       (en),
    .slow_ack (slow_ack),
    .stall    (stall),
    .restore  (restore),
    .data_out (data_out),
    .slow_req (slow_req),
    .speed_up (speed_up),
    .err_cnt  (err_cnt),
    .busy     (busy)
  );

  error_recovery_ctrl #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .err_in   (err2),
    .shadow_d (shadow_d),
    .en       (en2),
    .slow_ack (1'b0),
    .stall    (stall2),
    .restore  (restore2),
    .data_out (data_out2),
    .slow_req (slow_req2),
    .speed_up (speed_up2),
    .err_cnt  (err_cnt2),
    .busy     (busy2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    err_in   = 1'b0;
    slow_ack = 1'b0;
    en       = 1'b1;
    err2     = 1'b0;
    en2      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, at;
    logic [9:0] mask;

    rst = 1'b1; err_in = 1'b0; en = 1'b1; slow_ack = 1'b0; shadow_d = 3'd0;
    err2 = 1'b0; en2 = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stall",    32'(stall),    0);
    chk("rst_restore",  32'(restore),  0);
    chk("rst_data",     32'(data_out), 0);
    chk("rst_slow_req", 32'(slow_req), 0);
    chk("rst_speed_up", 32'(speed_up), 0);
    chk("rst_err_cnt",  32'(err_cnt),  0);
    chk("rst_busy",     32'(busy),     0);
    rst = 1'b0;

    // Single error, en dropped mid-recovery must not abort it.
    shadow_d = 3'd5;
    @(negedge clk);
    chk("idle_follow", 32'(data_out), 5);
    err_in = 1'b1;
    @(negedge clk);
    chk("a_restore", 32'(restore),  1);
    chk("a_stall",   32'(stall),    1);
    chk("a_busy",    32'(busy),     1);
    chk("a_data",    32'(data_out), 5);
    chk("a_err_cnt", 32'(err_cnt),  1);
    err_in = 1'b0; en = 1'b0; shadow_d = 3'd2;
    cnt_a = 1; cnt_b = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cnt_a += int'(stall);
      cnt_b += int'(restore);
      if (i == 0) chk("a_data_hold", 32'(data_out), 5);
    end
    chk("a_stall_cycles",   32'(cnt_a), 3);
    chk("a_restore_cycles", 32'(cnt_b), 1);
    chk("a_data_follow",    32'(data_out), 2);
    chk("a_err_cnt_end",    32'(err_cnt), 1);
    en = 1'b1;

    // err_in held for 10 edges: recoveries every 4th edge.
    do_reset();
    err_in = 1'b1; mask = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (restore) mask[i] = 1'b1;
    end
    err_in = 1'b0;
    chk("b_restore_mask", 32'(mask), 32'h111);
    chk("b_err_cnt", 32'(err_cnt), 3);
    repeat (4) @(negedge clk);
    chk("b_busy_end",  32'(busy),     0);
    chk("b_err_cnt2",  32'(err_cnt),  3);
    chk("b_slow_req",  32'(slow_req), 0);

    // Four separated errors trip the slow request; window freezes until ack.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      err_in = 1'b1;
      @(negedge clk);
      err_in = 1'b0;
      if (k == 3) begin
        chk("c_slow_pre", 32'(slow_req), 0);
        @(negedge clk);
        chk("c_slow_rise", 32'(slow_req), 1);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
    chk("c_err_cnt", 32'(err_cnt), 4);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      cnt_a += int'(slow_req);
      cnt_b += int'(speed_up);
    end
    chk("c_slow_hold",       32'(cnt_a), 70);
    chk("c_no_speedup_slow", 32'(cnt_b), 0);
    slow_ack = 1'b1;
    @(negedge clk);
    slow_ack = 1'b0;
    chk("c_slow_drop", 32'(slow_req), 0);
    cnt_b = 0; at = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (speed_up) begin
        cnt_b++;
        at = i;
      end
    end
    chk("c_speedup_count", 32'(cnt_b), 1);
    chk("c_speedup_at",    32'(at),    64);
    chk("c_slow_after",    32'(slow_req), 0);

    // Asynchronous reset in the first replay cycle.
    do_reset();
    shadow_d = 3'd6;
    err_in = 1'b1;
    @(negedge clk);
    err_in = 1'b0;
    @(negedge clk);
    chk("d_pre_stall", 32'(stall), 1);
    #2 rst = 1'b1;
    #1;
    chk("d_stall",    32'(stall),    0);
    chk("d_restore",  32'(restore),  0);
    chk("d_busy",     32'(busy),     0);
    chk("d_data",     32'(data_out), 0);
    chk("d_err_cnt",  32'(err_cnt),  0);
    chk("d_slow_req", 32'(slow_req), 0);
    chk("d_speed_up", 32'(speed_up), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cnt_a += int'(speed_up);
      cnt_b += int'(stall);
    end
    chk("d_no_speedup", 32'(cnt_a), 0);
    chk("d_no_stall",   32'(cnt_b), 0);

    // Narrow counter saturation, then en=0 ignores errors.
    do_reset();
    err2 = 1'b1; cnt_a = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      cnt_a += int'(restore2);
    end
    err2 = 1'b0;
    chk("e_accepts",  32'(cnt_a),    5);
    chk("e_sat_cnt",  32'(err_cnt2), 3);
    repeat (4) @(negedge clk);
    en2 = 1'b0; err2 = 1'b1; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cnt_b += int'(stall2);
    end
    err2 = 1'b0;
    chk("e_en0_stall", 32'(cnt_b),    0);
    chk("e_en0_cnt",   32'(err_cnt2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
